rv32m_divider: RTL

RV32M_DIVIDER -- requirements
Module: rv32m_divider

---
 rtl/rv32m_divider.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rv32m_divider.sv
// rv32m_divider: RV32M DIV/DIVU/REM/REMU, restoring radix-2 iterative divider.
// One quotient bit per cycle on operand magnitudes; sign fix-up and the
// divide-by-zero / signed-overflow special results are applied when the
// result register is written.
// Build option: define DIV_FAST_SPECIAL_EN to send divide-by-zero and signed
// overflow straight from IDLE to DONE (done in cycle 2) instead of running
// the full 32 iterations. Result values are the same in both builds.
module rv32m_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST_SPECIAL = 1'b1;
`else
    localparam bit FAST_SPECIAL = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] rem_r;   // partial remainder (always < divisor, so 32 bits hold it)
    logic [31:0] quo_r;   // dividend magnitude shifted out, quotient bits shifted in
    logic [31:0] dvs_r;   // divisor magnitude

    logic [32:0] shifted, diff;
    logic        qbit;
    logic [31:0] rem_nx, quo_nx;
    logic [31:0] a_mag, b_mag;
    logic        special_in;

    // Final result: sign correction on magnitudes, then special-case overrides.
    // op[0]=0 is signed, op[1]=1 selects remainder.
    function automatic logic [31:0] fixup(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] qm,
                                          input logic [31:0] rm);
        logic        sgn;
        logic [31:0] q, r;
        sgn = ~o[0];
        q   = (sgn && (x[31] ^ y[31])) ? -qm : qm;
        r   = (sgn && x[31]) ? -rm : rm;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end
        return o[1] ? r : q;
    endfunction

    // Operand magnitudes and early-out detection on the incoming request.
    always_comb begin
        a_mag      = (~op[0] & a[31]) ? -a : a;
        b_mag      = (~op[0] & b[31]) ? -b : b;
        special_in = (b == 32'd0) ||
                     (~op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    end

    // One restoring step: 33-bit shift-in, trial subtract, keep if non-negative.
    always_comb begin
        shifted = {rem_r, quo_r[31]};
        diff    = shifted - {1'b0, dvs_r};
        qbit    = ~diff[32];
        rem_nx  = qbit ? diff[31:0] : shifted[31:0];
        quo_nx  = {quo_r[30:0], qbit};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            op_r   <= 2'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            rem_r  <= 32'd0;
            quo_r  <= 32'd0;
            dvs_r  <= 32'd0;
            result <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        cnt   <= 5'd0;
                        rem_r <= 32'd0;
                        quo_r <= a_mag;
                        dvs_r <= b_mag;
                        if (FAST_SPECIAL && special_in) begin
                            result <= fixup(op, a, b, 32'd0, 32'd0);
                            state  <= S_DONE;
                        end else begin
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem_r <= rem_nx;
                        quo_r <= quo_nx;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result <= fixup(op_r, a_r, b_r, quo_nx, rem_nx);
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

endmodule
